// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch state encoding and default datapath/RAM widths.
package cpu_pkg;

    localparam int ADDR_W_DEF  = 8;
    localparam int INSTR_W_DEF = 16;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fetch_state_e;

    // Bits needed to hold any count from 0 to n inclusive.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO for the prefetch queue; flush empties it in one cycle.
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        push,
    input  logic [WIDTH-1:0]            push_data,
    input  logic                        pop,
    input  logic                        flush,
    output logic [WIDTH-1:0]            pop_data,
    output logic [cnt_width(DEPTH)-1:0] count,
    output logic                        full,
    output logic                        empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = cnt_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    // NOTE: non-blocking assignments here so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // NOTE: storage is left unreset; entries are only read once count says they were written.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC, credit-limited RAM reads, prefetch queue, valid/ready output.
// Define FETCH_PERF_EN to add saturating fetch_cnt / flush_cnt outputs.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF,
    parameter int DEPTH   = 4,
    parameter int RAM_LAT = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [ADDR_W-1:0]  start_pc,
    input  logic               stop,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               mem_rd_en,
    output logic [ADDR_W-1:0]  mem_rd_addr,
    input  logic [INSTR_W-1:0] mem_rd_data,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr_out,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic [ADDR_W-1:0]  fetch_pc,
    output logic               busy
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]        fetch_cnt,
    output logic [15:0]        flush_cnt
`endif
);

    localparam int Q_W    = INSTR_W + ADDR_W;
    localparam int CNT_W  = cnt_width(DEPTH);
    localparam int IF_W   = cnt_width(RAM_LAT);
    localparam int CRED_W = cnt_width(DEPTH + RAM_LAT) + 1;

    fetch_state_e      state;
    fetch_state_e      state_nxt;
    logic [ADDR_W-1:0] fetch_pc_nxt;
    logic              flush;
    logic              issue;
    logic              credit_ok;

    logic [RAM_LAT-1:0] inf_valid;
    logic [ADDR_W-1:0]  inf_pc [RAM_LAT];
    logic [IF_W-1:0]    in_flight;

    logic             q_push;
    logic             q_pop;
    logic [Q_W-1:0]   q_data;
    logic [CNT_W-1:0] q_count;
    logic             q_full;
    logic             q_empty;

    always_comb begin
        in_flight = '0;
        for (int i = 0; i < RAM_LAT; i++) begin
            in_flight = in_flight + IF_W'(inf_valid[i]);
        end
    end

    // Reads still in the RAM pipeline hold queue slots, so the queue can never overflow.
    assign credit_ok = (CRED_W'(q_count) + CRED_W'(in_flight)) < CRED_W'(DEPTH);

    // stop > start > redirect; a flush cycle never issues, the target is fetched next cycle.
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        flush        = 1'b0;
        issue        = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt    = RUN;
                    flush        = 1'b1;
                    fetch_pc_nxt = start_pc;
                end
            end
            RUN: begin
                if (stop) begin
                    state_nxt = IDLE;
                    flush     = 1'b1;
                end else if (start) begin
                    flush        = 1'b1;
                    fetch_pc_nxt = start_pc;
                end else if (redirect) begin
                    flush        = 1'b1;
                    fetch_pc_nxt = redirect_pc;
                end else if (credit_ok) begin
                    issue        = 1'b1;
                    fetch_pc_nxt = fetch_pc + ADDR_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            fetch_pc <= '0;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
        end
    end

    // In-flight pipeline mirrors the RAM latency; a flush kills every stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inf_valid <= '0;
            for (int i = 0; i < RAM_LAT; i++) begin
                inf_pc[i] <= '0;
            end
        end else begin
            inf_valid[0] <= issue;
            inf_pc[0]    <= fetch_pc;
            for (int i = RAM_LAT - 1; i > 0; i--) begin
                inf_valid[i] <= inf_valid[i-1] && !flush;
                inf_pc[i]    <= inf_pc[i-1];
            end
        end
    end

    assign q_push = inf_valid[RAM_LAT-1] && !flush;
    assign q_pop  = instr_valid && instr_ready;

    fetch_queue #(
        .WIDTH (Q_W),
        .DEPTH (DEPTH)
    ) u_fetch_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (q_push),
        .push_data ({mem_rd_data, inf_pc[RAM_LAT-1]}),
        .pop       (q_pop),
        .flush     (flush),
        .pop_data  (q_data),
        .count     (q_count),
        .full      (q_full),
        .empty     (q_empty)
    );

    assign mem_rd_en   = issue;
    assign mem_rd_addr = fetch_pc;
    assign busy        = (state == RUN);
    assign instr_valid = !q_empty;
    // Head fields read as zero while empty so stale storage never shows on the outputs.
    assign instr_out   = q_empty ? '0 : q_data[Q_W-1:ADDR_W];
    assign instr_pc    = q_empty ? '0 : q_data[ADDR_W-1:0];

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (issue && fetch_cnt != 16'hFFFF) begin
                fetch_cnt <= fetch_cnt + 16'd1;
            end
            if (flush && flush_cnt != 16'hFFFF) begin
                flush_cnt <= flush_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: two instances (RAM_LAT 1 and 2) with RAM models and a PC scoreboard.
module tb_instr_fetch_unit;

    localparam int AW    = 8;
    localparam int IW    = 16;
    localparam int DEPTH = 4;
    localparam int K_START = 0;
    localparam int K_REDIR = 1;
    localparam int K_STOP  = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]         start_s, stop_s, redir_s, ready_s;
    logic [1:0][AW-1:0] spc_s, rpc_s;
    logic [1:0]         rd_en, ivalid, busy;
    logic [1:0][AW-1:0] rd_addr, ipc, fpc;
    logic [1:0][IW-1:0] rd_data, iout;
`ifdef FETCH_PERF_EN
    logic [1:0][15:0]   fcnt, flcnt;
`endif

    function automatic logic [IW-1:0] ram_word(input logic [AW-1:0] a);
        return {a ^ 8'hA5, ~a};
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [IW-1:0] d0, d1;
        always @(posedge clk) begin
            d0 <= rd_en[g] ? ram_word(rd_addr[g]) : 16'hBAD0;
            d1 <= d0;
        end
        assign rd_data[g] = (g == 0) ? d0 : d1;

        instr_fetch_unit #(
            .ADDR_W  (AW),
            .INSTR_W (IW),
            .DEPTH   (DEPTH),
            .RAM_LAT (g + 1)
        ) u_dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .start       (start_s[g]),
            .start_pc    (spc_s[g]),
            .stop        (stop_s[g]),
            .redirect    (redir_s[g]),
            .redirect_pc (rpc_s[g]),
            .mem_rd_en   (rd_en[g]),
            .mem_rd_addr (rd_addr[g]),
            .mem_rd_data (rd_data[g]),
            .instr_valid (ivalid[g]),
            .instr_ready (ready_s[g]),
            .instr_out   (iout[g]),
            .instr_pc    (ipc[g]),
            .fetch_pc    (fpc[g]),
            .busy        (busy[g])
`ifdef FETCH_PERF_EN
            ,
            .fetch_cnt   (fcnt[g]),
            .flush_cnt   (flcnt[g])
`endif
        );
    end

    logic [AW-1:0] q0[$];
    logic [AW-1:0] q1[$];
    logic [AW-1:0] exp_fa[2];
    bit   [1:0]    hold;
    bit   [1:0]    fl_prev;
    int            issued[2], first_rd[2], first_v[2], first_acc[2], last_acc[2], start_cyc[2];
    int            cyc = 0;
    int            n_chk = 0;
    int            n_pass = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int qsize(input int i);
        return (i == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic [AW-1:0] qfront(input int i);
        return (i == 0) ? q0[0] : q1[0];
    endfunction

    task automatic qpop(input int i);
        if (i == 0) void'(q0.pop_front());
        else void'(q1.pop_front());
    endtask

    task automatic qpush_range(input int i, input logic [AW-1:0] first, input int n);
        logic [AW-1:0] pc;
        pc = first;
        for (int k = 0; k < n; k++) begin
            if (i == 0) q0.push_back(pc);
            else q1.push_back(pc);
            pc = pc + 8'd1;
        end
    endtask

    task automatic arm(input int i);
        issued[i]    = 0;
        first_rd[i]  = -1;
        first_v[i]   = -1;
        first_acc[i] = -1;
        last_acc[i]  = -1;
        start_cyc[i] = cyc;
    endtask

    // One clock: drive ready, sample #1 after the negedge, then wait for the next negedge.
    task automatic cycle();
        logic [31:0] e;
        for (int i = 0; i < 2; i++) ready_s[i] = !hold[i] && (qsize(i) != 0);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (fl_prev[i]) check($sformatf("valid_after_flush%0d", i), 32'(ivalid[i]), 32'd0);
            if (rd_en[i]) begin
                check($sformatf("rd_addr%0d", i), 32'(rd_addr[i]), 32'(exp_fa[i]));
                exp_fa[i] = exp_fa[i] + 8'd1;
                issued[i]++;
                if (first_rd[i] < 0) first_rd[i] = cyc;
            end
            if (ivalid[i] && first_v[i] < 0) first_v[i] = cyc;
            if (ivalid[i] && ready_s[i]) begin
                e = (qsize(i) != 0) ? 32'(qfront(i)) : 32'hDEAD_BEEF;
                check($sformatf("instr_pc%0d", i), 32'(ipc[i]), e);
                if (qsize(i) != 0) begin
                    check($sformatf("instr_out%0d", i), 32'(iout[i]), 32'(ram_word(qfront(i))));
                    qpop(i);
                end
                if (first_acc[i] < 0) first_acc[i] = cyc;
                last_acc[i] = cyc;
            end
            fl_prev[i] = start_s[i] || stop_s[i] || (redir_s[i] && busy[i]);
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    task automatic pulse(input int i, input int kind, input logic [AW-1:0] pc);
        case (kind)
            K_START: begin start_s[i] = 1'b1; spc_s[i] = pc; exp_fa[i] = pc; end
            K_REDIR: begin redir_s[i] = 1'b1; rpc_s[i] = pc; exp_fa[i] = pc; end
            default: stop_s[i] = 1'b1;
        endcase
        arm(i);
        cycle();
        start_s[i] = 1'b0;
        redir_s[i] = 1'b0;
        stop_s[i]  = 1'b0;
    endtask

    task automatic run_until(input int i, input int budget);
        int n;
        n = 0;
        while (qsize(i) != 0 && n < budget) begin
            cycle();
            n++;
        end
        check($sformatf("drain%0d", i), 32'(qsize(i)), 32'd0);
    endtask

    task automatic check_zero(input int i, input string tag);
        check({tag, "_rd_en"},  32'(rd_en[i]),  32'd0);
        check({tag, "_valid"},  32'(ivalid[i]), 32'd0);
        check({tag, "_out"},    32'(iout[i]),   32'd0);
        check({tag, "_ipc"},    32'(ipc[i]),    32'd0);
        check({tag, "_fpc"},    32'(fpc[i]),    32'd0);
        check({tag, "_addr"},   32'(rd_addr[i]), 32'd0);
        check({tag, "_busy"},   32'(busy[i]),   32'd0);
`ifdef FETCH_PERF_EN
        check({tag, "_fcnt"},   32'(fcnt[i]),   32'd0);
        check({tag, "_flcnt"},  32'(flcnt[i]),  32'd0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        start_s = '0; stop_s = '0; redir_s = '0; ready_s = '0;
        spc_s = '0; rpc_s = '0;
        hold = 2'b11; fl_prev = '0;
        exp_fa[0] = '0; exp_fa[1] = '0;
        arm(0); arm(1);

        repeat (3) @(negedge clk);
        #1;
        check_zero(0, "rst0");
        check_zero(1, "rst1");
        @(negedge clk);
        rst_n = 1'b1;
        hold  = 2'b00;
        idle(3);
        check("no_strobe_idle0", 32'(issued[0]), 32'd0);
        check("no_strobe_idle1", 32'(issued[1]), 32'd0);

        // Start at 10 with ready held high: streaming delivery, one per cycle.
        qpush_range(0, 8'h10, 8);
        pulse(0, K_START, 8'h10);
        check("busy_after_start", 32'(busy[0]), 32'd1);
        run_until(0, 40);
        check("issue_after_start", 32'(first_rd[0] - start_cyc[0]), 32'd1);
        check("latency_lat1", 32'(first_v[0] - first_rd[0]), 32'd2);
        check("throughput", 32'(last_acc[0] - first_acc[0]), 32'd7);
        pulse(0, K_STOP, 8'h00);
        check("busy_after_stop", 32'(busy[0]), 32'd0);

        // Consumer stalled: credit stops issue at DEPTH reads, then drains in order.
        hold[0] = 1'b1;
        qpush_range(0, 8'h10, 4);
        pulse(0, K_START, 8'h10);
        idle(8);
        check("credit_reads", 32'(issued[0]), 32'd4);
        check("full_valid", 32'(ivalid[0]), 32'd1);
        check("full_head", 32'(ipc[0]), 32'h10);
        qpush_range(0, 8'h14, 4);
        hold[0] = 1'b0;
        run_until(0, 40);
        pulse(0, K_STOP, 8'h00);

        // RAM_LAT=2: redirect with two reads in flight; stale data must not surface.
        pulse(1, K_START, 8'h20);
        idle(2);
        check("inflight_two", 32'(issued[1]), 32'd2);
        qpush_range(1, 8'h40, 6);
        pulse(1, K_REDIR, 8'h40);
        run_until(1, 40);
        check("latency_lat2", 32'(first_v[1] - first_rd[1]), 32'd3);
        pulse(1, K_STOP, 8'h00);

        // Address wrap at the top of the PC space.
        qpush_range(0, 8'hFE, 4);
        pulse(0, K_START, 8'hFE);
        run_until(0, 40);
        pulse(0, K_STOP, 8'h00);

        // Same-cycle stop and redirect: stop wins.
        qpush_range(1, 8'h30, 3);
        pulse(1, K_START, 8'h30);
        run_until(1, 40);
        stop_s[1] = 1'b1;
        redir_s[1] = 1'b1;
        rpc_s[1] = 8'h77;
        cycle();
        stop_s[1] = 1'b0;
        redir_s[1] = 1'b0;
        arm(1);
        idle(6);
        check("stop_redir_busy", 32'(busy[1]), 32'd0);
        check("stop_redir_reads", 32'(issued[1]), 32'd0);
        check("stop_redir_valid", 32'(ivalid[1]), 32'd0);

        // Asynchronous reset in the middle of a running fetch stream.
        qpush_range(0, 8'h50, 16);
        pulse(0, K_START, 8'h50);
        idle(5);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero(0, "async_rst");
        q0.delete();
        q1.delete();
        fl_prev = '0;
        arm(0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(5);
        check("no_strobe_after_reset", 32'(issued[0]), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
